// File: rtl/text_buffer_writer.sv
// text_buffer_writer: turns a character stream into screen-buffer writes with cursor and scroll tracking
module text_buffer_writer #(
  parameter int cols = 128,
  parameter int rows = 48,
  parameter int char_width = 8,
  parameter logic [char_width-1:0] blank_char = char_width'(8'h20),
  localparam int aw = $clog2(cols * rows),
  localparam int cw = $clog2(cols),
  localparam int rw = $clog2(rows)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [char_width-1:0] char_in,
  input  logic                  char_valid,
  output logic                  char_ready,
  output logic                  buf_we,
  output logic [aw-1:0]         buf_addr,
  output logic [char_width-1:0] buf_data,
  output logic [cw-1:0]         cursor_col,
  output logic [rw-1:0]         cursor_row,
  output logic [rw-1:0]         top_row,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, CLEAR, ROWCLR} state_t;
  state_t state;
  logic [aw:0] cnt;
  logic scrolled;
  logic printable, at_end, wrap, do_nl;
  logic [rw-1:0] nrow, nnrow;
  logic [aw-1:0] row_base, cur_addr;
  // decode the offered code and precompute cursor/scroll successors
  always_comb begin
    printable = char_in >= char_width'('h20) && char_in <= char_width'('h7E);
    at_end = cursor_col == cw'(cols - 1);
    wrap = cursor_row == rw'(rows - 1);
    nrow = wrap ? '0 : cursor_row + 1'b1;
    nnrow = (nrow == rw'(rows - 1)) ? '0 : nrow + 1'b1;
    row_base = aw'(cursor_row * cols);
    cur_addr = row_base + aw'(cursor_col);
    do_nl = (printable && at_end) || char_in == char_width'('h0A);
  end
  // clear sequencers plus code interpretation; every output is registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt <= '0;
      buf_we <= 1'b0;
      buf_addr <= '0;
      buf_data <= blank_char;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row <= '0;
      scrolled <= 1'b0;
      char_ready <= 1'b0;
      busy <= 1'b1;
    end else begin
      buf_we <= 1'b0;
      case (state)
        CLEAR:
          if (cnt == (aw+1)'(cols * rows)) begin
            state <= IDLE;
            char_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            buf_we <= 1'b1;
            buf_addr <= aw'(cnt);
            buf_data <= blank_char;
            cnt <= cnt + 1'b1;
          end
        ROWCLR:
          if (cnt == (aw+1)'(cols)) begin
            state <= IDLE;
            char_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            buf_we <= 1'b1;
            buf_addr <= row_base + aw'(cnt);
            buf_data <= blank_char;
            cnt <= cnt + 1'b1;
          end
        default:
          if (char_valid) begin
            if (printable) begin
              buf_we <= 1'b1;
              buf_addr <= cur_addr;
              buf_data <= char_in;
              if (!at_end) cursor_col <= cursor_col + 1'b1;
            end
            if (do_nl) begin
              cursor_col <= '0;
              cursor_row <= nrow;
              scrolled <= scrolled | wrap;
              top_row <= (scrolled | wrap) ? nnrow : '0;
              cnt <= '0;
              state <= ROWCLR;
              char_ready <= 1'b0;
              busy <= 1'b1;
            end
            if (char_in == char_width'('h0D)) cursor_col <= '0;
            if (char_in == char_width'('h08) && cursor_col != '0) begin
              cursor_col <= cursor_col - 1'b1;
              buf_we <= 1'b1;
              buf_addr <= cur_addr - 1'b1;
              buf_data <= blank_char;
            end
            if (char_in == char_width'('h0C)) begin
              cursor_col <= '0;
              cursor_row <= '0;
              scrolled <= 1'b0;
              top_row <= '0;
              cnt <= '0;
              state <= CLEAR;
              char_ready <= 1'b0;
              busy <= 1'b1;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_text_buffer_writer.sv
// tb_text_buffer_writer: directed checks of text_buffer_writer on a 4x3 screen
module tb_text_buffer_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic char_valid = 1'b0;
  logic char_ready, buf_we, busy;
  logic [3:0] buf_addr;
  logic [7:0] buf_data;
  logic [1:0] cursor_col, cursor_row, top_row;
  int checks = 0;
  int failures = 0;
  logic [12:0] wq[$];

  text_buffer_writer #(.cols(4), .rows(3), .char_width(8), .blank_char(8'h20)) dut (
    .clk(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .top_row(top_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // log every buffer write together with the ready flag seen in that cycle
  always @(negedge clk) if (buf_we === 1'b1) wq.push_back({char_ready, buf_addr, buf_data});

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expw(input string tag, input logic r, input logic [3:0] a, input logic [7:0] d);
    logic [12:0] o;
    o = 13'h1fff;
    if (wq.size() > 0) o = wq.pop_front();
    chk(tag, 32'(o), 32'({r, a, d}));
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    char_in = c;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("send_timeout", 32'(n < 100), 32'd1);
    tick(1);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (char_ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    tick(2);
    chk("rst_we", 32'(buf_we), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    chk("rst_top", 32'(top_row), 32'd0);
    reset = 1'b0;
    tick(12);
    chk("clr_last_we", 32'({buf_we, buf_addr, char_ready}), 32'({1'b1, 4'd11, 1'b0}));
    tick(1);
    chk("clr_done_ready", 32'({char_ready, busy, buf_we}), 32'({1'b1, 1'b0, 1'b0}));
    chk("clr_count", 32'(wq.size()), 32'd12);
    for (int i = 0; i < 12; i++) expw("init_clr", 1'b0, 4'(i), 8'h20);

    send(8'h41);
    send(8'h42);
    tick(1);
    expw("wr_A", 1'b1, 4'd0, 8'h41);
    expw("wr_B", 1'b1, 4'd1, 8'h42);
    chk("ab_cursor", 32'({cursor_row, cursor_col}), 32'({2'd0, 2'd2}));

    send(8'h0C);
    send(8'h41);
    send(8'h42);
    send(8'h43);
    send(8'h44);
    send(8'h45);
    tick(1);
    for (int i = 0; i < 12; i++) expw("ff_clr", 1'b0, 4'(i), 8'h20);
    expw("wrap_A", 1'b1, 4'd0, 8'h41);
    expw("wrap_B", 1'b1, 4'd1, 8'h42);
    expw("wrap_C", 1'b1, 4'd2, 8'h43);
    expw("wrap_D", 1'b0, 4'd3, 8'h44);
    for (int i = 4; i < 8; i++) expw("wrap_rowclr", 1'b0, 4'(i), 8'h20);
    expw("wrap_E", 1'b1, 4'd4, 8'h45);
    chk("wrap_cursor", 32'({cursor_row, cursor_col}), 32'({2'd1, 2'd1}));

    send(8'h0C);
    send(8'h0A);
    chk("nl1_pos", 32'({cursor_row, cursor_col, top_row}), 32'({2'd1, 2'd0, 2'd0}));
    send(8'h0A);
    chk("nl2_pos", 32'({cursor_row, top_row}), 32'({2'd2, 2'd0}));
    send(8'h0A);
    chk("nl3_pos", 32'({cursor_row, cursor_col, top_row}), 32'({2'd0, 2'd0, 2'd1}));
    wait_idle();
    for (int i = 0; i < 12; i++) expw("ff2_clr", 1'b0, 4'(i), 8'h20);
    for (int i = 4; i < 12; i++) expw("nl_rowclr", 1'b0, 4'(i), 8'h20);
    for (int i = 0; i < 4; i++) expw("scroll_rowclr", 1'b0, 4'(i), 8'h20);
    send(8'h0C);
    chk("ff_top", 32'({top_row, busy}), 32'({2'd0, 1'b1}));
    wait_idle();
    for (int i = 0; i < 12; i++) expw("ff3_clr", 1'b0, 4'(i), 8'h20);

    send(8'h08);
    chk("bs0_we", 32'(buf_we), 32'd0);
    tick(1);
    chk("bs0_nowrite", 32'(wq.size()), 32'd0);
    chk("bs0_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    send(8'h58);
    send(8'h59);
    send(8'h08);
    tick(1);
    expw("wr_X", 1'b1, 4'd0, 8'h58);
    expw("wr_Y", 1'b1, 4'd1, 8'h59);
    expw("bs_blank", 1'b1, 4'd1, 8'h20);
    chk("bs_cursor", 32'({cursor_row, cursor_col}), 32'({2'd0, 2'd1}));

    send(8'h0D);
    chk("cr_we", 32'(buf_we), 32'd0);
    chk("cr_cursor", 32'({cursor_row, cursor_col}), 32'd0);

    send(8'h0A);
    tick(3);
    chk("rowclr_3rd", 32'({buf_we, buf_addr}), 32'({1'b1, 4'd6}));
    reset = 1'b1;
    tick(1);
    chk("abort_state", 32'({buf_we, char_ready, busy}), 32'({1'b0, 1'b0, 1'b1}));
    chk("abort_pos", 32'({cursor_row, cursor_col, top_row}), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("restart_first", 32'({buf_we, buf_addr, buf_data}), 32'({1'b1, 4'd0, 8'h20}));
    wait_idle();
    for (int i = 4; i < 7; i++) expw("partial_rowclr", 1'b0, 4'(i), 8'h20);
    for (int i = 0; i < 12; i++) expw("restart_clr", 1'b0, 4'(i), 8'h20);

    send(8'h1B);
    chk("esc_state", 32'({buf_we, char_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
    chk("esc_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    tick(1);
    chk("esc_nowrite", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
